fifo_vc_buffer: RTL
===================

// Module: fifo_vc_buffer
// PURPOSE
//   Per-virtual-channel FIFO placed directly downstream of the 1x2 class demux; one
//   instance sits on each demux output, with push_0/out0 driving VC0 and push_1/out1
//   driving VC1. It buffers 10-bit words until the arbiter/egress stage pops them.
//   It reports occupancy flags, which the flow-control logic uses for backpressure.
// PARAMETERS
//   DATA_WIDTH  10  word width; matches demux output width
//   ADDR_WIDTH  2   pointer width; depth = 2**ADDR_WIDTH (4 words)
//   AF_THRESH   3   almost_full asserts when count >= AF_THRESH
//   AE_THRESH   1   almost_empty asserts when count <= AE_THRESH
// PORTS
//   clk           in   1             single clock; all state updates on the rising edge
//   reset         in   1             asynchronous, active-low reset; 0 = reset
//   push          in   1             write request; connects to demux push_N
//   data_in       in   DATA_WIDTH    write data; connects to demux outN
//   pop           in   1             read request from the downstream stage
//   data_out      out  DATA_WIDTH    registered read data
//   data_valid    out  1             high for 1 cycle when data_out carries a popped word
//   full          out  1             count == 2**ADDR_WIDTH
//   empty         out  1             count == 0
//   almost_full   out  1             count >= AF_THRESH
//   almost_empty  out  1             count <= AE_THRESH
//   count         out  ADDR_WIDTH+1  current occupancy, range 0..2**ADDR_WIDTH
//   fifo_error    out  1             overflow/underflow indication
// BEHAVIOUR
//   - Reset (async, reset==0): wr_ptr=rd_ptr=count=0, data_out=0, data_valid=0,
//     fifo_error=0 -> empty=1, almost_empty=1, full=0, almost_full=0.
//     Takes effect immediately, even mid-transfer. Stored words are discarded;
//     the memory array itself is not cleared.
//   - Flags are decoded from the registered count only; no combinational path
//     from push or pop to any flag.
//   - Push accepted iff !full, or (full && pop). The word is written at wr_ptr,
//     and wr_ptr increments modulo depth (natural wrap, no special case).
//   - Pop accepted iff !empty. On the next edge, data_out <= mem[rd_ptr],
//     data_valid <= 1, and rd_ptr increments modulo depth. With no accepted pop,
//     data_valid <= 0 and data_out holds its last value. Read latency is 1 cycle.
//   - No fall-through: a word pushed in cycle N can be popped in cycle N+1 at
//     the earliest, and appears on data_out at N+2.
//   - count update: +1 on accepted push only, -1 on accepted pop only,
//     unchanged when both are accepted or neither is.
//   - Full with push and pop together: both are accepted; count stays at depth.
//   - Empty with push and pop together: the pop is rejected (underflow), the push
//     is accepted, and count goes to 1.
//   - Overflow (push && full && !pop): the word is dropped and state is unchanged.
//   - Underflow (pop && empty): no read, data_valid=0, state is unchanged.
//   - fifo_error: registered; set on the edge after an overflow or underflow
//     (mode depends on FIFO_ERR_STICKY_EN).
// CONFIGURATION
//   FIFO_ERR_STICKY_EN defined: fifo_error stays at 1 after the first
//     overflow/underflow and clears only on reset.
//   FIFO_ERR_STICKY_EN undefined: fifo_error is a 1-cycle pulse on the edge
//     after each offending request, and is 0 otherwise.
// TESTING (defaults: depth 4, AF=3, AE=1)
//   1. Assert reset=0 asynchronously mid-clock with count=2 -> immediately count=0,
//      empty=1, almost_empty=1, data_valid=0, data_out=0.
//   2. Push 0x001,0x002,0x003,0x004 on consecutive cycles -> count 1,2,3,4;
//      almost_empty drops at count=2, almost_full rises at count=3, full at 4.
//   3. Full FIFO, push 0x3FF without pop -> word dropped, count=4, fifo_error=1;
//      then 4 pops -> data_out 0x001..0x004 with data_valid=1 each cycle.
//   4. Full FIFO, push 0x155 and pop in the same cycle -> count stays 4, next
//      data_out = oldest word, 0x155 read last; no error.
//   5. Empty FIFO, push 0x2AA and pop together -> fifo_error asserts, count=1,
//      data_valid=0; pop next cycle -> data_out=0x2AA, data_valid=1.
//   6. Run 10 push/pop pairs through depth 4 (pointer wrap) -> output order equals
//      input order; with the macro defined, an earlier error stays at 1.

Source files
------------

// File: rtl/fifo_vc_buffer.sv
// fifo_vc_buffer: per-virtual-channel FIFO that sits on one output of the class demux.
// It holds words until the egress arbiter pops them and exposes occupancy flags
// for backpressure. Reset is asynchronous and active-low.
// Optional macro FIFO_ERR_STICKY_EN: when defined, fifo_error latches until reset;
// when undefined, fifo_error pulses for one cycle per offending request.
module fifo_vc_buffer #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 2,
  parameter int AF_THRESH  = 3,
  parameter int AE_THRESH  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  fifo_error
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CNT_W = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;

  logic push_ok;
  logic pop_ok;
  logic overflow;
  logic underflow;

  // Flags come only from the registered count so flow control never sees a
  // combinational path from this cycle's push/pop.
  assign full         = (count == CNT_W'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CNT_W'(AF_THRESH));
  assign almost_empty = (count <= CNT_W'(AE_THRESH));

  // A full FIFO can still take a word when a pop frees the slot in the same cycle;
  // an empty FIFO never serves a pop, even when a push arrives alongside it.
  assign pop_ok    = pop && !empty;
  assign push_ok   = push && (!full || pop);
  assign overflow  = push && full && !pop;
  assign underflow = pop && empty;

  // Storage array: written on accepted pushes only, never cleared by reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers, occupancy and the registered read port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        data_out   <= mem[rd_ptr];
        rd_ptr     <= rd_ptr + 1'b1;
        data_valid <= 1'b1;
      end else begin
        data_valid <= 1'b0;
      end
      if (push_ok && !pop_ok) begin
        count <= count + 1'b1;
      end else if (!push_ok && pop_ok) begin
        count <= count - 1'b1;
      end
    end
  end

  // Error flag for dropped pushes and rejected pops, sticky or pulsed by build option.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_error <= 1'b0;
    end else begin
`ifdef FIFO_ERR_STICKY_EN
      if (overflow || underflow) begin
        fifo_error <= 1'b1;
      end
`else
      fifo_error <= overflow || underflow;
`endif
    end
  end

endmodule
